// File: rtl/data_island_scheduler_pkg.sv
// Shared encodings and timing constants for the HDMI data-island scheduler.
package data_island_pkg;

  typedef enum logic [1:0] {
    PHASE_CTL      = 2'd0,
    PHASE_PREAMBLE = 2'd1,
    PHASE_GUARD    = 2'd2,
    PHASE_PACKET   = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_PREAMBLE,
    ST_LEAD_GB,
    ST_PACKET,
    ST_TRAIL_GB
  } state_e;

  localparam int unsigned PREAMBLE_LEN     = 8;
  localparam int unsigned GUARD_LEN        = 2;
  localparam int unsigned PACKET_LEN       = 32;
  localparam int unsigned ISLAND_OVERHEAD  = PREAMBLE_LEN + 2 * GUARD_LEN;
  localparam int unsigned HDMI_MAX_PACKETS = 18;

  // Encoder phase presented for each FSM state.
  function automatic phase_e phase_of(input state_e s);
    case (s)
      ST_PREAMBLE:            return PHASE_PREAMBLE;
      ST_LEAD_GB, ST_TRAIL_GB: return PHASE_GUARD;
      ST_PACKET:              return PHASE_PACKET;
      default:                return PHASE_CTL;
    endcase
  endfunction

endpackage

// File: rtl/data_island_scheduler_if.sv
// Window/request inputs and island timing outputs of the data-island scheduler.
interface data_island_scheduler_if #(
  parameter int unsigned NUM_SOURCES = 4
);
  localparam int unsigned SEL_W = $clog2(NUM_SOURCES);

  logic                   windowStart;
  logic [11:0]            windowLength;
  logic [NUM_SOURCES-1:0] req;
  logic [NUM_SOURCES-1:0] ack;
  logic [SEL_W-1:0]       packetSel;
  logic                   dataIslandActive;
  logic [1:0]             phase;
  logic                   isFirstPacketClock;
  logic                   isFirstIslandPacket;
  logic [4:0]             packetIndex;
  logic                   busy;

  // Scheduler side.
  modport master (
    input  windowStart, windowLength, req,
    output ack, packetSel, dataIslandActive, phase,
           isFirstPacketClock, isFirstIslandPacket, packetIndex, busy
  );

  // Packet sources / video timing side.
  modport slave (
    output windowStart, windowLength, req,
    input  ack, packetSel, dataIslandActive, phase,
           isFirstPacketClock, isFirstIslandPacket, packetIndex, busy
  );
endinterface

// File: rtl/data_island_scheduler_round_robin_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module round_robin_arbiter #(
  parameter int unsigned NUM_SOURCES = 4,
  parameter int unsigned SEL_W       = 2
) (
  input  logic [NUM_SOURCES-1:0] req_i,
  input  logic [SEL_W-1:0]       ptr_i,
  output logic [SEL_W-1:0]       grant_o,
  output logic                   valid_o
);

  logic [SEL_W-1:0] idx;

  // Scan from the pointer; the first hit in scan order wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      idx = SEL_W'((32'(ptr_i) + i) % NUM_SOURCES);
      if (!valid_o && req_i[idx]) begin
        grant_o = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_island_scheduler.sv
// HDMI data-island sequencer: fits islands into blanking windows and shares
// the packet serializer between sources slot by slot.
module data_island_scheduler
  import data_island_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = 4,
  parameter int unsigned MAX_PACKETS = HDMI_MAX_PACKETS,
  parameter int unsigned LEAD_DELAY  = 4
) (
  input  logic                    pixelClock,
  input  logic                    reset,
  data_island_scheduler_if.master bus
);

  localparam int unsigned SEL_W = $clog2(NUM_SOURCES);

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [4:0]             char_q, char_d;
  logic [4:0]             pktIdx_q, pktIdx_d;
  logic [11:0]            rem_q, rem_d;
  // ptr_q is the next search start (lastGrant+1); reset value 0 makes the
  // first search after reset begin at source 0.
  logic [SEL_W-1:0]       ptr_q, ptr_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [NUM_SOURCES-1:0] ack_q, ack_d;

  logic                   accept;
  logic                   cont;
  logic                   decide;
  logic [SEL_W-1:0]       arb_grant;
  logic                   arb_valid;
  logic [SEL_W-1:0]       last_grant;

  round_robin_arbiter #(
    .NUM_SOURCES (NUM_SOURCES),
    .SEL_W       (SEL_W)
  ) u_arb (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .valid_o (arb_valid)
  );

  assign last_grant = (ptr_q == '0) ? SEL_W'(NUM_SOURCES - 1) : ptr_q - SEL_W'(1);

  assign accept = bus.windowStart && (|bus.req) &&
                  ({1'b0, bus.windowLength} >= 13'(LEAD_DELAY + ISLAND_OVERHEAD + PACKET_LEN));

  assign cont = (|bus.req) &&
                (pktIdx_q < 5'(MAX_PACKETS - 1)) &&
                (rem_q >= 12'(PACKET_LEN + GUARD_LEN + 1));

  // Next-state, counters and slot arbitration.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    char_d   = char_q;
    pktIdx_d = pktIdx_q;
    rem_d    = (rem_q != '0) ? rem_q - 12'd1 : '0;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    ack_d    = '0;
    decide   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rem_d    = bus.windowLength;
          cnt_d    = '0;
          pktIdx_d = '0;
          state_d  = (LEAD_DELAY == 0) ? ST_PREAMBLE : ST_LEAD;
        end
      end
      ST_LEAD: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(LEAD_DELAY - 1)) begin
          cnt_d   = '0;
          state_d = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(PREAMBLE_LEN - 1)) begin
          cnt_d   = '0;
          state_d = ST_LEAD_GB;
        end
      end
      ST_LEAD_GB: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(GUARD_LEN - 1)) begin
          cnt_d   = '0;
          char_d  = '0;
          decide  = 1'b1;
          state_d = ST_PACKET;
        end
      end
      ST_PACKET: begin
        char_d = char_q + 5'd1;
        if (char_q == 5'(PACKET_LEN - 1)) begin
          if (cont) begin
            decide   = 1'b1;
            pktIdx_d = pktIdx_q + 5'd1;
          end else begin
            cnt_d   = '0;
            state_d = ST_TRAIL_GB;
          end
        end
      end
      ST_TRAIL_GB: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(GUARD_LEN - 1)) begin
          cnt_d    = '0;
          pktIdx_d = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // With no requester at the first slot the previous source is re-selected
    // and no ack is issued, so downstream sends a null packet.
    if (decide) begin
      if (arb_valid) begin
        sel_d = arb_grant;
        ack_d = NUM_SOURCES'(1) << arb_grant;
        ptr_d = (arb_grant == SEL_W'(NUM_SOURCES - 1)) ? '0 : arb_grant + SEL_W'(1);
      end else begin
        sel_d = last_grant;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      char_q   <= '0;
      pktIdx_q <= '0;
      rem_q    <= '0;
      ptr_q    <= '0;
      sel_q    <= '0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      char_q   <= char_d;
      pktIdx_q <= pktIdx_d;
      rem_q    <= rem_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      ack_q    <= ack_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    bus.ack                 = ack_q;
    bus.packetSel           = sel_q;
    bus.packetIndex         = pktIdx_q;
    bus.phase               = phase_of(state_q);
    bus.busy                = (state_q != ST_IDLE);
    bus.dataIslandActive    = (state_q != ST_IDLE) && (state_q != ST_LEAD);
    bus.isFirstPacketClock  = (state_q == ST_PACKET) && (char_q == '0);
    bus.isFirstIslandPacket = (state_q == ST_PACKET) && (pktIdx_q == '0);
  end

endmodule

// File: tb/tb_data_island_scheduler.sv
// Directed bench for data_island_scheduler with a slot scoreboard.
`define CHK(tag, obs, exp) \
  begin \
    n_checks++; \
    assert ((obs) === (exp)) else begin \
      n_fail++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
    end \
  end

module tb_data_island_scheduler;

  localparam int LD = 4;
  localparam int NS = 4;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] ack;
    logic [4:0] idx;
  } slot_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    ptr      = 0;
  slot_t sb[$];

  data_island_scheduler_if #(.NUM_SOURCES(NS)) bif ();

  data_island_scheduler #(
    .NUM_SOURCES (NS),
    .MAX_PACKETS (18),
    .LEAD_DELAY  (LD)
  ) dut (
    .pixelClock (clk),
    .reset      (rst),
    .bus        (bif.master)
  );

  always #5 clk = ~clk;

  function automatic int rr(input logic [3:0] r, input int p);
    for (int i = 0; i < NS; i++) begin
      int j;
      j = (p + i) % NS;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic check_zero_outputs(input string pfx);
    `CHK({pfx, "_ack"}, bif.ack, 4'h0)
    `CHK({pfx, "_sel"}, bif.packetSel, 2'd0)
    `CHK({pfx, "_dia"}, bif.dataIslandActive, 1'b0)
    `CHK({pfx, "_phase"}, bif.phase, 2'd0)
    `CHK({pfx, "_fpc"}, bif.isFirstPacketClock, 1'b0)
    `CHK({pfx, "_fip"}, bif.isFirstIslandPacket, 1'b0)
    `CHK({pfx, "_pidx"}, bif.packetIndex, 5'd0)
    `CHK({pfx, "_busy"}, bif.busy, 1'b0)
  endtask

  // One window: expected slots are pushed before windowStart is driven,
  // then popped at every packet character 0.
  task automatic run_island(input int wl, input logic [3:0] r_ws, input logic [3:0] r_isl,
                            input bit one_shot, input int rst_cycle);
    bit         accept, cont;
    int         n, t_end, rem, g, last_k, pstart, exp_ph;
    logic [3:0] rq, cur_req;
    slot_t      s;
    bit         exp_busy, exp_dia, fpc;

    accept = (wl >= LD + 44) && (r_ws != 4'h0);
    n      = 0;
    if (accept) begin
      rq = r_isl;
      do begin
        if (rq == 4'h0) begin
          s.sel = 2'((ptr + NS - 1) % NS);
          s.ack = 4'h0;
        end else begin
          g     = rr(rq, ptr);
          s.sel = 2'(g);
          s.ack = 4'(1 << g);
          ptr   = (g + 1) % NS;
          if (one_shot) rq = rq & ~s.ack;
        end
        s.idx = 5'(n);
        sb.push_back(s);
        rem  = wl - (LD + 10 + 32 * (n + 1) - 1);
        cont = (rq != 4'h0) && (n < 17) && (rem >= 35);
        n++;
      end while (cont);
    end
    pstart = LD + 11;
    t_end  = LD + 10 + 32 * n + 2;
    last_k = accept ? t_end + 3 : 8;

    bif.windowStart  = 1'b1;
    bif.windowLength = 12'(wl);
    bif.req          = r_ws;
    cur_req          = r_isl;

    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      if (!accept) begin
        `CHK("rej_busy", bif.busy, 1'b0)
        `CHK("rej_phase", bif.phase, 2'd0)
      end else begin
        exp_busy = 1'b1;
        exp_dia  = 1'b1;
        if (k <= LD) begin
          exp_ph  = 0;
          exp_dia = 1'b0;
        end else if (k <= LD + 8) exp_ph = 1;
        else if (k <= LD + 10) exp_ph = 2;
        else if (k <= LD + 10 + 32 * n) exp_ph = 3;
        else if (k <= t_end) exp_ph = 2;
        else begin
          exp_ph   = 0;
          exp_busy = 1'b0;
          exp_dia  = 1'b0;
        end
        `CHK("phase", bif.phase, 2'(exp_ph))
        `CHK("busy", bif.busy, exp_busy)
        `CHK("dia", bif.dataIslandActive, exp_dia)
        fpc = (exp_ph == 3) && (((k - pstart) % 32) == 0);
        `CHK("first_pkt_clk", bif.isFirstPacketClock, fpc)
        if (fpc) begin
          n_checks++;
          assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL sb_underflow observed=%0d expected=%0d", sb.size(), 1);
          end
          if (sb.size() > 0) begin
            s = sb.pop_front();
            `CHK("packetSel", bif.packetSel, s.sel)
            `CHK("ack", bif.ack, s.ack)
            `CHK("packetIndex", bif.packetIndex, s.idx)
            `CHK("first_isl_pkt", bif.isFirstIslandPacket, (s.idx == 5'd0))
            if (one_shot) cur_req = cur_req & ~s.ack;
          end
        end else begin
          `CHK("ack_idle", bif.ack, 4'h0)
        end
      end

      if (k == rst_cycle) begin
        rst = 1'b1;
        bif.windowStart = 1'b0;
        bif.req = 4'h0;
        #1;
        check_zero_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        ptr = 0;
        sb.delete();
        break;
      end

      // Stray windowStart pulses mid-island and on the last trailing guard cycle.
      bif.windowStart  = accept && (k == 20 || k == t_end);
      bif.windowLength = bif.windowStart ? 12'hFFF : 12'(wl);
      bif.req          = cur_req;
    end

    if (accept && rst_cycle < 0) begin
      `CHK("sb_leftover", sb.size(), 0)
    end
    bif.windowStart = 1'b0;
    bif.req         = 4'h0;
    @(negedge clk);
  endtask

  initial begin
    bif.windowStart  = 1'b0;
    bif.windowLength = 12'd0;
    bif.req          = 4'h0;
    rst              = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single packet, source 0 drops request after ack.
    run_island(100, 4'b0001, 4'b0001, 1'b1, -1);
    // All sources held: round-robin order until the window runs out.
    run_island(400, 4'b1111, 4'b1111, 1'b0, -1);
    // Acceptance boundary.
    run_island(47, 4'b0001, 4'b0001, 1'b1, -1);
    run_island(48, 4'b0010, 4'b0010, 1'b1, -1);
    // Packet-count cap.
    run_island(4095, 4'b1111, 4'b1111, 1'b0, -1);
    // Reset at packet character 10, then pointer restarts at 0.
    run_island(400, 4'b1111, 4'b1111, 1'b0, LD + 21);
    run_island(100, 4'b1111, 4'b1111, 1'b1, -1);
    // Request withdrawn during lead: one null packet.
    run_island(200, 4'b0100, 4'b0000, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
